rename_unit: RTL and testbench

Parametrised, WIDTH-wide register-rename stage between decode and dispatch. Each accepted group gets physical source tags from a speculative RAT and fresh destination tags from a free-list bitmap, with intra-group dependencies resolved in lane order. A retire port maintains an architectural RAT and free list and returns superseded tags. A flush restores the speculative state from the architectural state in one cycle.

---
 rtl/rename_unit.sv | 157 +++++++++++++++
 tb/tb_rename_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// rename_unit: WIDTH-wide register rename stage with speculative/architectural RATs, free-list bitmaps and one-cycle flush recovery
module rename_unit #(
    parameter int WIDTH = 2,
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 128,
    parameter int PW = $clog2(NUM_PREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH*5-1:0]  in_rs1,
    input  logic [WIDTH*5-1:0]  in_rs2,
    input  logic [WIDTH*5-1:0]  in_rd,
    input  logic [WIDTH-1:0]    in_we,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH*PW-1:0] out_ps1,
    output logic [WIDTH*PW-1:0] out_ps2,
    output logic [WIDTH*PW-1:0] out_pd,
    output logic [WIDTH*PW-1:0] out_old_pd,
    output logic [WIDTH-1:0]    out_we,
    input  logic [WIDTH-1:0]    ret_valid,
    input  logic [WIDTH*5-1:0]  ret_rd,
    input  logic [WIDTH*PW-1:0] ret_pd,
    input  logic [WIDTH*PW-1:0] ret_old_pd,
    input  logic                flush,
    output logic [PW:0]         free_count
);
    localparam logic [NUM_PREGS-1:0] FREE0 = {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};

    logic [PW-1:0]       spec_rat [NUM_AREGS];
    logic [PW-1:0]       arch_rat [NUM_AREGS];
    logic [PW-1:0]       srat_n   [NUM_AREGS];
    logic [PW-1:0]       arat_n   [NUM_AREGS];
    logic [NUM_PREGS-1:0] spec_free, arch_free, sfree_n, afree_n;
    logic [PW:0]         cnt_n;
    logic [PW-1:0]       pick [WIDTH];
    logic [WIDTH-1:0]    alloc;
    logic [WIDTH*PW-1:0] ps1_c, ps2_c, pd_c, old_c;
    logic [4:0]          s1, s2, d;
    logic [PW-1:0]       t1, t2, to, pdv;
    logic                accept;
    int                  c, j;

    assign in_ready = !flush && (!out_valid || out_ready) && free_count >= (PW+1)'(WIDTH);
    assign accept = in_valid && in_ready;

    // pick the WIDTH lowest free tags, then rename each lane with bypass from earlier lanes in the group
    always_comb begin
        c = 0;
        j = 0;
        s1 = '0;
        s2 = '0;
        d = '0;
        t1 = '0;
        t2 = '0;
        to = '0;
        pdv = '0;
        alloc = '0;
        ps1_c = '0;
        ps2_c = '0;
        pd_c = '0;
        old_c = '0;
        for (int q = 0; q < WIDTH; q++) pick[q] = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            for (int q = 0; q < WIDTH; q++) if (spec_free[i] && c == q) pick[q] = PW'(i);
            c += spec_free[i] ? 1 : 0;
        end
        for (int k = 0; k < WIDTH; k++) begin
            s1 = in_rs1[5*k +: 5];
            s2 = in_rs2[5*k +: 5];
            d = in_rd[5*k +: 5];
            alloc[k] = in_we[k] && d != 5'd0;
            t1 = spec_rat[s1];
            t2 = spec_rat[s2];
            to = spec_rat[d];
            for (int m = 0; m < k; m++) begin
                if (alloc[m] && in_rd[5*m +: 5] == s1) t1 = pd_c[PW*m +: PW];
                if (alloc[m] && in_rd[5*m +: 5] == s2) t2 = pd_c[PW*m +: PW];
                if (alloc[m] && in_rd[5*m +: 5] == d) to = pd_c[PW*m +: PW];
            end
            pdv = '0;
            for (int q = 0; q < WIDTH; q++) if (q == j) pdv = pick[q];
            ps1_c[PW*k +: PW] = t1;
            ps2_c[PW*k +: PW] = t2;
            pd_c[PW*k +: PW] = alloc[k] ? pdv : '0;
            old_c[PW*k +: PW] = alloc[k] ? to : '0;
            j += alloc[k] ? 1 : 0;
        end
    end

    // retire updates arch state first; accept then edits spec state; flush overrides spec with the updated arch state
    always_comb begin
        arat_n = arch_rat;
        afree_n = arch_free;
        srat_n = spec_rat;
        sfree_n = spec_free;
        for (int k = 0; k < WIDTH; k++) begin
            if (ret_valid[k] && ret_rd[5*k +: 5] != 5'd0) begin
                arat_n[ret_rd[5*k +: 5]] = ret_pd[PW*k +: PW];
                afree_n[ret_pd[PW*k +: PW]] = 1'b0;
                afree_n[ret_old_pd[PW*k +: PW]] = 1'b1;
                sfree_n[ret_old_pd[PW*k +: PW]] = 1'b1;
            end
        end
        for (int k = 0; k < WIDTH; k++) begin
            if (accept && alloc[k]) begin
                srat_n[in_rd[5*k +: 5]] = pd_c[PW*k +: PW];
                sfree_n[pd_c[PW*k +: PW]] = 1'b0;
            end
        end
        if (flush) begin
            srat_n = arat_n;
            sfree_n = afree_n;
        end
        cnt_n = '0;
        for (int i = 0; i < NUM_PREGS; i++) cnt_n += (PW+1)'(sfree_n[i]);
    end

    // rename tables, free lists, free-tag count and the output group register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                spec_rat[i] <= PW'(i);
                arch_rat[i] <= PW'(i);
            end
            spec_free <= FREE0;
            arch_free <= FREE0;
            free_count <= (PW+1)'(NUM_PREGS - NUM_AREGS);
            out_valid <= 1'b0;
            out_ps1 <= '0;
            out_ps2 <= '0;
            out_pd <= '0;
            out_old_pd <= '0;
            out_we <= '0;
        end else begin
            spec_rat <= srat_n;
            arch_rat <= arat_n;
            spec_free <= sfree_n;
            arch_free <= afree_n;
            free_count <= cnt_n;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_ps1 <= ps1_c;
                out_ps2 <= ps2_c;
                out_pd <= pd_c;
                out_old_pd <= old_c;
                out_we <= alloc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed vectors with hand-computed tags for rename_unit
module tb_rename_unit;
    localparam int W = 2;
    localparam int PW = 7;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready, flush;
    logic [W*5-1:0] in_rs1, in_rs2, in_rd, ret_rd;
    logic [W-1:0] in_we, out_we, ret_valid;
    logic [W*PW-1:0] out_ps1, out_ps2, out_pd, out_old_pd, ret_pd, ret_old_pd;
    logic [PW:0] free_count;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rename_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_ps1(out_ps1), .out_ps2(out_ps2),
        .out_pd(out_pd), .out_old_pd(out_old_pd), .out_we(out_we),
        .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_pd(ret_pd), .ret_old_pd(ret_old_pd),
        .flush(flush), .free_count(free_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f(input logic [W*PW-1:0] v, input int k);
        return 32'(v[PW*k +: PW]);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] a1, a2, ad, input logic aw, input logic [4:0] b1, b2, bd, input logic bw);
        in_rs1 = {b1, a1};
        in_rs2 = {b2, a2};
        in_rd = {bd, ad};
        in_we = {bw, aw};
    endtask

    task automatic issue(input logic [4:0] a1, a2, ad, input logic aw, input logic [4:0] b1, b2, bd, input logic bw);
        drive(a1, a2, ad, aw, b1, b2, bd, bw);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic retire(input logic [4:0] rd, input logic [PW-1:0] pd, input logic [PW-1:0] old);
        ret_valid = 2'b01;
        ret_rd = {5'd0, rd};
        ret_pd = {7'd0, pd};
        ret_old_pd = {7'd0, old};
        step();
        ret_valid = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        ret_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = '0;
        ret_rd = '0; ret_pd = '0; ret_old_pd = '0;
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_free", 32'(free_count), 96);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_pd", 32'(out_pd), 0);

        issue(1, 2, 5, 1, 5, 3, 6, 1);
        chk("g1_valid", 32'(out_valid), 1);
        chk("g1_ps1_0", f(out_ps1, 0), 1);
        chk("g1_ps2_0", f(out_ps2, 0), 2);
        chk("g1_pd_0", f(out_pd, 0), 32);
        chk("g1_old_0", f(out_old_pd, 0), 5);
        chk("g1_ps1_1", f(out_ps1, 1), 32);
        chk("g1_ps2_1", f(out_ps2, 1), 3);
        chk("g1_pd_1", f(out_pd, 1), 33);
        chk("g1_old_1", f(out_old_pd, 1), 6);
        chk("g1_we", 32'(out_we), 3);
        chk("g1_free", 32'(free_count), 94);

        issue(0, 0, 7, 1, 0, 0, 7, 1);
        chk("g2_pd_0", f(out_pd, 0), 34);
        chk("g2_old_0", f(out_old_pd, 0), 7);
        chk("g2_pd_1", f(out_pd, 1), 35);
        chk("g2_old_1", f(out_old_pd, 1), 34);

        issue(7, 0, 0, 0, 7, 5, 0, 0);
        chk("g3_ps1_0", f(out_ps1, 0), 35);
        chk("g3_ps2_0_x0", f(out_ps2, 0), 0);
        chk("g3_ps1_1", f(out_ps1, 1), 35);
        chk("g3_ps2_1", f(out_ps2, 1), 32);
        chk("g3_we", 32'(out_we), 0);
        chk("g3_pd_1", f(out_pd, 1), 0);
        chk("g3_free", 32'(free_count), 92);

        issue(6, 0, 9, 0, 0, 6, 8, 1);
        chk("sw_ps1_0", f(out_ps1, 0), 33);
        chk("sw_pd_0", f(out_pd, 0), 0);
        chk("sw_old_0", f(out_old_pd, 0), 0);
        chk("sw_we", 32'(out_we), 2);
        chk("sw_pd_1", f(out_pd, 1), 36);
        chk("sw_old_1", f(out_old_pd, 1), 8);
        chk("sw_ps2_1", f(out_ps2, 1), 33);
        chk("sw_free", 32'(free_count), 91);

        issue(0, 0, 0, 1, 0, 0, 10, 1);
        chk("x0_pd_0", f(out_pd, 0), 0);
        chk("x0_we", 32'(out_we), 2);
        chk("x0_pd_1", f(out_pd, 1), 37);
        chk("x0_free", 32'(free_count), 90);

        for (int i = 0; i < 45; i++) issue(0, 0, 10, 1, 0, 0, 11, 1);
        chk("ex_pd_0", f(out_pd, 0), 126);
        chk("ex_pd_1", f(out_pd, 1), 127);
        chk("ex_free", 32'(free_count), 0);
        chk("ex_ready", 32'(in_ready), 0);
        retire(7, 34, 7);
        chk("ex_ret1_free", 32'(free_count), 1);
        chk("ex_ret1_ready", 32'(in_ready), 0);
        retire(5, 32, 5);
        chk("ex_ret2_free", 32'(free_count), 2);
        chk("ex_ret2_ready", 32'(in_ready), 1);
        issue(0, 0, 12, 1, 0, 0, 13, 1);
        chk("ex_reuse_pd_0", f(out_pd, 0), 5);
        chk("ex_reuse_pd_1", f(out_pd, 1), 7);
        chk("ex_reuse_free", 32'(free_count), 0);

        do_reset();
        chk("rst2_free", 32'(free_count), 96);
        issue(0, 0, 5, 1, 0, 0, 0, 0);
        chk("fl_pd_a", f(out_pd, 0), 32);
        chk("fl_free_a", 32'(free_count), 95);
        drive(0, 0, 5, 1, 0, 0, 0, 0);
        in_valid = 1'b1;
        retire(5, 32, 5);
        in_valid = 1'b0;
        chk("fl_pd_b", f(out_pd, 0), 33);
        chk("fl_old_b", f(out_old_pd, 0), 32);
        chk("fl_free_b", 32'(free_count), 95);
        flush = 1'b1;
        #1;
        chk("fl_ready", 32'(in_ready), 0);
        step();
        flush = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 0);
        chk("fl_free", 32'(free_count), 96);
        issue(5, 0, 6, 1, 5, 0, 5, 1);
        chk("fl_ps1_0", f(out_ps1, 0), 32);
        chk("fl_pd_0", f(out_pd, 0), 5);
        chk("fl_old_0", f(out_old_pd, 0), 6);
        chk("fl_ps1_1", f(out_ps1, 1), 32);
        chk("fl_pd_1", f(out_pd, 1), 33);
        chk("fl_old_1", f(out_old_pd, 1), 32);
        chk("fl_free_c", 32'(free_count), 94);

        issue(1, 2, 20, 1, 3, 4, 21, 1);
        chk("st_pd_0", f(out_pd, 0), 34);
        chk("st_pd_1", f(out_pd, 1), 35);
        chk("st_free", 32'(free_count), 92);
        out_ready = 1'b0;
        drive(1, 1, 22, 1, 2, 2, 23, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_ready", 32'(in_ready), 0);
            step();
            chk("st_valid", 32'(out_valid), 1);
            chk("st_pd_hold", f(out_pd, 0), 34);
            chk("st_free_hold", 32'(free_count), 92);
        end
        rst = 1'b1;
        #1;
        chk("st_rst_valid", 32'(out_valid), 0);
        chk("st_rst_free", 32'(free_count), 96);
        chk("st_rst_pd", f(out_pd, 0), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("end_ready", 32'(in_ready), 1);
        chk("end_free", 32'(free_count), 96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
